// File: rtl/sext_accum.sv
// -----------------------------------------------------------------------------
// sext_accum
//
// Windowed signed accumulator that sits directly after the sign-extension
// stage. It accepts M-bit signed samples over a valid/ready handshake and sums
// each group of exactly LEN accepted samples at full precision. The window
// total is presented as an S-bit result with its own valid/ready handshake.
// S = M + $clog2(LEN) is wide enough that the sum can never overflow.
//
// Optional feature macro: SEXT_ACCUM_AVG_EN
//   When it is defined, o_sum carries the rounded (half-up) window mean
//   instead of the raw sum. LEN must then be a power of two.
//
// Ports:
//   i_clk    - clock; all state updates on the rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_x      - M-bit signed sample, already sign-extended
//   i_valid  - i_x is valid
//   o_ready  - a sample is accepted this cycle (depends on FSM state only)
//   o_sum    - S-bit signed window result (registered)
//   o_valid  - o_sum is valid (registered)
//   i_ready  - downstream accepts o_sum
//   o_busy   - a partial window or an unconsumed result is held (registered)
// -----------------------------------------------------------------------------
module sext_accum #(
    parameter int M   = 6,
    parameter int LEN = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [M-1:0]                  i_x,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [M+$clog2(LEN)-1:0]      o_sum,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_busy
);

    localparam int S  = M + $clog2(LEN);
    localparam int CW = $clog2(LEN);

    // The LEN-th sample of a window arrives when the counter reads LEN-1.
    localparam logic [CW-1:0] LAST_COUNT = CW'(LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [S-1:0]    acc;
    logic [CW-1:0]   count;

    logic [S-1:0]    x_ext;
    logic [S-1:0]    window_sum;
    logic [S-1:0]    result;

    // Sign-extend the sample to the accumulator width. S-M is always at
    // least one because LEN >= 2.
    assign x_ext      = {{(S - M){i_x[M-1]}}, i_x};

    // Running total including the sample currently on the input. On the
    // last sample of a window this is the complete window sum.
    assign window_sum = acc + x_ext;

`ifdef SEXT_ACCUM_AVG_EN
    localparam int K = CW;

    // The mean is taken with a plain arithmetic shift, so the window length
    // must be an exact power of two.
    if ((1 << K) != LEN) begin : g_len_not_pow2
        $error("sext_accum: LEN must be a power of two when averaging is enabled");
    end

    logic signed [S:0] rounded;

    // One spare bit keeps the rounding bias safe. The biased value never
    // exceeds the S-bit range, so the shifted result fits back into S bits.
    assign rounded = $signed({window_sum[S-1], window_sum}) + (S + 1)'(1 << (K - 1));
    assign result  = S'(rounded >>> K);
`else
    assign result  = window_sum;
`endif

    // Ready depends on the FSM state only. There is no combinational path
    // from i_valid or i_ready, and no sample is taken while a result is
    // pending.
    assign o_ready = (state == ACC);

    // Single FSM. In ACC it accumulates accepted samples. On the LEN-th
    // sample it latches the window result, clears the running state and
    // moves to HOLD. HOLD keeps o_sum stable until the downstream handshake.
    // Busy rises on any accept and falls only when the result is consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ACC;
            acc     <= '0;
            count   <= '0;
            o_sum   <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (i_valid) begin
                        o_busy <= 1'b1;
                        if (count == LAST_COUNT) begin
                            o_sum   <= result;
                            acc     <= '0;
                            count   <= '0;
                            o_valid <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            acc   <= window_sum;
                            count <= count + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sext_accum.sv
// -----------------------------------------------------------------------------
// tb_sext_accum
//
// Directed testbench for sext_accum (M=6, LEN=4, S=8). A behavioural model
// collects accepted samples into a queue. When the queue holds LEN samples it
// forms the window result with integer arithmetic. A compare process checks
// the DUT against that model on every falling edge. Hand-computed literal
// results pin the model. The literal values follow SEXT_ACCUM_AVG_EN when it
// is defined.
// -----------------------------------------------------------------------------
module tb_sext_accum;

    localparam int M   = 6;
    localparam int LEN = 4;
    localparam int S   = M + $clog2(LEN);

    logic           i_clk;
    logic           i_rst_n;
    logic [M-1:0]   i_x;
    logic           i_valid;
    logic           o_ready;
    logic [S-1:0]   o_sum;
    logic           o_valid;
    logic           i_ready;
    logic           o_busy;

    int n_tests;
    int n_fail;

    sext_accum #(.M(M), .LEN(LEN)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_x     (i_x),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_sum   (o_sum),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    // 10 time-unit clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------------------------------------------------------------
    // Behavioural model. It works from the inputs alone: a sample counts as
    // taken when it is offered while no result is pending.
    // ---------------------------------------------------------------------
    int     window_q[$];
    logic   m_pending;
    int     m_result;

    function automatic int window_value(input int q[$]);
        int total;
        total = 0;
        foreach (q[i]) total += q[i];
`ifdef SEXT_ACCUM_AVG_EN
        return (total + LEN / 2) >>> $clog2(LEN);
`else
        return total;
`endif
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            window_q.delete();
            m_pending = 1'b0;
            m_result  = 0;
        end else if (m_pending) begin
            if (i_ready) m_pending = 1'b0;
        end else if (i_valid) begin
            window_q.push_back(int'($signed(i_x)));
            if (window_q.size() == LEN) begin
                m_result  = window_value(window_q);
                m_pending = 1'b1;
                window_q.delete();
            end
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge i_clk) begin
        logic [S-1:0] exp_sum;
        logic         exp_busy;
        exp_sum  = S'(m_result);
        exp_busy = m_pending || (window_q.size() != 0);

        n_tests++;
        if (o_ready !== !m_pending) begin
            n_fail++;
            $display("[TB] FAIL ready t=%0t got=%b exp=%b", $time, o_ready, !m_pending);
        end
        n_tests++;
        if (o_valid !== m_pending) begin
            n_fail++;
            $display("[TB] FAIL valid t=%0t got=%b exp=%b", $time, o_valid, m_pending);
        end
        n_tests++;
        if (o_busy !== exp_busy) begin
            n_fail++;
            $display("[TB] FAIL busy t=%0t got=%b exp=%b", $time, o_busy, exp_busy);
        end
        if (m_pending) begin
            n_tests++;
            if (o_sum !== exp_sum) begin
                n_fail++;
                $display("[TB] FAIL sum t=%0t got=%h exp=%h", $time, o_sum, exp_sum);
            end
        end
    end

    // Picks the hand-computed literal that matches the build.
    function automatic logic [S-1:0] pick(input logic [S-1:0] raw, input logic [S-1:0] avg);
`ifdef SEXT_ACCUM_AVG_EN
        return avg;
`else
        return raw;
`endif
    endfunction

    // Offers one sample for one edge, then idles for gap cycles. Inputs
    // change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [M-1:0] x, input int gap);
        i_x     = x;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (gap) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Checks a literal expectation on the presented result.
    task automatic checkOutput(input string name, input logic [S-1:0] exp_sum);
        n_tests++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== exp_sum) begin
            n_fail++;
            $display("[TB] FAIL %s got sum=%h valid=%b ready=%b exp sum=%h valid=1 ready=0",
                     name, o_sum, o_valid, o_ready, exp_sum);
        end
    endtask

    // Checks that every output shows its reset value.
    task automatic checkReset(input string name);
        n_tests++;
        if (o_sum !== '0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s got sum=%h valid=%b ready=%b busy=%b exp 00/0/1/0",
                     name, o_sum, o_valid, o_ready, o_busy);
        end
    endtask

    // Consumes the pending result with a one-cycle i_ready pulse.
    task automatic drain();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_rst_n = 1'b0;
        i_x     = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;

        #2;
        checkReset("reset_initial");
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Four -1 back to back
        repeat (4) applyStimulus(6'h3F, 0);
        checkOutput("neg_one", pick(8'hFC, 8'hFF));
        drain();

        // Most negative and most positive samples
        repeat (4) applyStimulus(6'h20, 0);
        checkOutput("min_sample", pick(8'h80, 8'hE0));
        drain();
        repeat (4) applyStimulus(6'h1F, 0);
        checkOutput("max_sample", pick(8'h7C, 8'h1F));
        drain();

        // Gapped samples 5, -3, 7, -9
        applyStimulus(6'd5, 2);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_after_first got=%b exp=1", o_busy);
        end
        applyStimulus(6'h3D, 2);
        applyStimulus(6'd7, 2);
        applyStimulus(6'h37, 0);
        checkOutput("gapped_zero", pick(8'h00, 8'h00));
        drain();

        // Window of 2s, then a stalled output with samples offered
        repeat (4) applyStimulus(6'd2, 0);
        i_x     = 6'd1;
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall_hold", pick(8'h08, 8'h02));
            @(posedge i_clk);
            #1;
        end
        checkOutput("stall_end", pick(8'h08, 8'h02));
        i_valid = 1'b0;
        drain();
        repeat (4) applyStimulus(6'd1, 0);
        checkOutput("after_stall", pick(8'h04, 8'h01));
        drain();

        // Mid-window asynchronous reset
        applyStimulus(6'd10, 0);
        applyStimulus(6'd10, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkReset("reset_mid_window");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (4) applyStimulus(6'd1, 0);
        checkOutput("after_reset", pick(8'h04, 8'h01));

        // Reset while a result is pending
        #2;
        i_rst_n = 1'b0;
        #1;
        checkReset("reset_in_hold");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Rounding vectors
        applyStimulus(6'd1, 0);
        applyStimulus(6'd1, 0);
        applyStimulus(6'd1, 0);
        applyStimulus(6'd0, 0);
        checkOutput("round_up", pick(8'h03, 8'h01));
        drain();
        applyStimulus(6'h3F, 0);
        applyStimulus(6'h3F, 0);
        applyStimulus(6'h3F, 0);
        applyStimulus(6'h3E, 0);
        checkOutput("round_neg", pick(8'hFB, 8'hFF));
        drain();

        repeat (3) @(posedge i_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sext_accum.md
# sext_accum

Windowed signed accumulator placed directly downstream of the sign-extension stage. It consumes a stream of M-bit sign-extended samples under a valid/ready handshake and sums each group of exactly LEN accepted samples at full precision. Each window total is presented as one S-bit result with its own valid/ready handshake. The block is the first sequential stage after `signext` in the operand datapath and turns per-sample values into per-window totals.

## Interface
- `M`, default 6: sample width; equals the `signext` output width. Must be ≥ 2.
- `LEN`, default 4: number of samples per window. Must be ≥ 2.
- `S` (localparam) = `M + $clog2(LEN)`: result width. It is the exact two's-complement range for LEN samples.
- `i_clk`, input, 1: the single clock. All state updates on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_x`, input, M: signed sample, already sign-extended.
- `i_valid`, input, 1: `i_x` is valid.
- `o_ready`, output, 1: block accepts a sample this cycle.
- `o_sum`, output, S: signed window result.
- `o_valid`, output, 1: `o_sum` is valid.
- `i_ready`, input, 1: downstream accepts `o_sum`.
- `o_busy`, output, 1: high while the block holds a partial window, i.e. at least one sample accepted since the last result handshake or reset.

## Operation
- Two-state FSM: `ACC` (reset state) and `HOLD`.
- Input handshake: a sample is accepted when `i_valid && o_ready` at a rising edge. Output handshake: a result is accepted when `o_valid && i_ready` at a rising edge.
- In `ACC`:
  - `o_ready`=1 and `o_valid`=0.
  - On each accepted sample, the S-bit accumulator adds `i_x` sign-extended to S bits, and the count increments.
  - When the accepted sample is the LEN-th one (count = LEN-1):
    - `o_sum` is loaded with accumulator + `i_x`.
    - The accumulator and count clear.
    - The FSM moves to `HOLD`.
- In `HOLD`:
  - `o_ready`=0 and `o_valid`=1.
  - `o_sum` stays stable until the output handshake.
  - On the output handshake the FSM returns to `ACC`.
- Idle cycles (`i_valid`=0) in `ACC` leave all state unchanged. Window membership counts accepted samples, not cycles.
- Arithmetic is exact two's complement. No overflow is possible at width S.
- `o_busy` = (`ACC` and count ≠ 0) or `HOLD`.
- Reset (asynchronous, any time, including mid-window or in `HOLD`):
  - FSM goes to `ACC`; accumulator = 0; count = 0.
  - `o_sum` = 0, `o_valid` = 0, `o_ready` = 1, `o_busy` = 0.
  - A partial window or an unconsumed result is discarded.

## Timing
- Latency: `o_valid` rises in the cycle after the edge that accepts the LEN-th sample.
- `o_ready` falls in that same cycle. No sample is accepted while a result is pending; this is a no-skid design.
- Minimum period per window is LEN+1 cycles: LEN accept cycles plus one `HOLD` cycle with `i_ready`=1.
- `o_ready` is a function of FSM state only. It has no combinational path from `i_valid` or `i_ready`.
- `o_sum`, `o_valid` and `o_busy` are registered.
- Reset deassertion must be synchronous to `i_clk` externally. The first accept can happen on the first edge after release.

## Configuration
- Macro: `SEXT_ACCUM_AVG_EN`.
- Defined: `o_sum` carries the rounded window mean instead of the raw sum.
  - Formula: (sum + 2^(k-1)) >>> k, where k = log2(LEN); rounding is half-up.
  - The result is sign-extended to S bits.
  - LEN must be a power of two; elaboration fails otherwise.
- Not defined: `o_sum` is the raw sum, and any LEN ≥ 2 is legal.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
Defaults for all scenarios: M=6, LEN=4, S=8.
- Four accepts of -1 (6'h3F) back-to-back → `o_valid` the next cycle with `o_sum`=8'hFC; `o_ready` low in that cycle.
- Four accepts of -32 (6'h20) → `o_sum`=8'h80. Four accepts of +31 (6'h1F) → `o_sum`=8'h7C.
- Samples 5, -3, 7, -9 with 2-cycle `i_valid` gaps between them → exactly one result, `o_sum`=0. `o_busy` high from the first accept until the output handshake.
- Window complete, then `i_ready` held low 5 cycles while `i_valid`=1 with value 1 → `o_sum` stable and `o_ready`=0 throughout. After the handshake, the next window of four 1s gives `o_sum`=8'h04.
- Two samples of 10 accepted, then `i_rst_n` pulsed low mid-cycle → all outputs take reset values immediately. Four subsequent samples of 1 give `o_sum`=8'h04.
- With `SEXT_ACCUM_AVG_EN` defined:
  - Samples 1, 1, 1, 0 → `o_sum`=8'h01.
  - Samples -1, -1, -1, -2 → `o_sum`=8'hFF.
